// File: rtl/icache_sa.sv
// Set-associative read-only instruction cache with burst line refill,
// per-set LRU replacement, whole-cache invalidate and hit/miss counters.
`timescale 1ns/1ps

module icache_sa #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SETS   = 16,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic              cpu_req_valid,
  output logic [DATA_W-1:0] cpu_req_data,
  output logic              cpu_req_ready,
  input  logic              inv_req,
  output logic              inv_busy,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_valid,
  input  logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] hit_cnt,
  output logic [ADDR_W-1:0] miss_cnt
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int unsigned WA_W  = ADDR_W - 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    REFILL  = 3'd2,
    RESPOND = 3'd3,
    FLUSH   = 3'd4
  } state_t;

  state_t             state;
  logic [WA_W-1:0]    addr_q;
  logic [OFF_W-1:0]   beat;
  logic               victim;
  logic [DATA_W-1:0]  word_q;
  logic               inv_pend;
  logic [IDX_W-1:0]   flush_idx;

  logic               valid_q  [WAYS][SETS];
  logic [TAG_W-1:0]   tag_q    [WAYS][SETS];
  logic               lru_q    [SETS];
  logic [DATA_W-1:0]  data_mem [WAYS][SETS*WORDS];

  logic [OFF_W-1:0]   req_off;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               hit_way;
  logic               inv_found;
  logic               inv_way;
  logic               victim_sel;
  logic               beat_last;
  logic               beat_fire;
  logic [DATA_W-1:0]  hit_word;
  logic               unused_bits;

  assign unused_bits = ^cpu_req_addr[1:0];

  assign req_off = addr_q[0 +: OFF_W];
  assign req_idx = addr_q[OFF_W +: IDX_W];
  assign req_tag = addr_q[WA_W-1 -: TAG_W];

  assign beat_last = (beat == OFF_W'(WORDS - 1));
  assign beat_fire = (state == REFILL) && mem_req_ready;

  always_comb begin
    hit       = 1'b0;
    hit_way   = 1'b0;
    inv_found = 1'b0;
    inv_way   = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = w[0];
      end
      if (!inv_found && !valid_q[w][req_idx]) begin
        inv_found = 1'b1;
        inv_way   = w[0];
      end
    end
  end

  // LRU bit names the way to evict once both ways hold valid lines.
  assign victim_sel = inv_found ? inv_way : ((WAYS == 2) ? lru_q[req_idx] : 1'b0);
  assign hit_word   = data_mem[hit_way][{req_idx, req_off}];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      beat      <= '0;
      victim    <= 1'b0;
      word_q    <= '0;
      inv_pend  <= 1'b0;
      flush_idx <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
        end
      end
    end else begin
      if (inv_req && (state != IDLE) && (state != FLUSH)) begin
        inv_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (inv_pend || inv_req) begin
            inv_pend  <= 1'b0;
            flush_idx <= '0;
            state     <= FLUSH;
          end else if (cpu_req_valid) begin
            addr_q <= cpu_req_addr[ADDR_W-1:2];
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            word_q  <= hit_word;
            hit_cnt <= hit_cnt + 1'b1;
            if (WAYS == 2) begin
              lru_q[req_idx] <= ~hit_way;
            end
            state <= RESPOND;
          end else begin
            victim   <= victim_sel;
            miss_cnt <= miss_cnt + 1'b1;
            beat     <= '0;
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (mem_req_ready) begin
            if (beat == req_off) begin
              word_q <= mem_req_data;
            end
            if (beat_last) begin
              valid_q[victim][req_idx] <= 1'b1;
              if (WAYS == 2) begin
                lru_q[req_idx] <= ~victim;
              end
              beat  <= '0;
              state <= RESPOND;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        RESPOND: state <= IDLE;
        FLUSH: begin
          lru_q[flush_idx] <= 1'b0;
          for (int unsigned w = 0; w < WAYS; w++) begin
            valid_q[w][flush_idx] <= 1'b0;
          end
          if (flush_idx == IDX_W'(SETS - 1)) begin
            state <= IDLE;
          end else begin
            flush_idx <= flush_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Arrays without reset; writes only happen in REFILL, which reset leaves at once.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      data_mem[victim][{req_idx, beat}] <= mem_req_data;
      if (beat_last) begin
        tag_q[victim][req_idx] <= req_tag;
      end
    end
  end

  assign cpu_req_ready = (state == RESPOND);
  assign cpu_req_data  = word_q;
  assign mem_req_valid = (state == REFILL);
  assign mem_req_addr  = mem_req_valid ? {req_tag, req_idx, beat, 2'b00} : '0;
  assign inv_busy      = inv_pend || (state == FLUSH);

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa (SETS=16, WORDS=4, WAYS=2) with a
// combinational instruction-memory model and per-step immediate assertions.
`timescale 1ns/1ps

module tb_icache_sa;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_req_addr;
  logic        cpu_req_valid;
  logic [31:0] cpu_req_data;
  logic        cpu_req_ready;
  logic        inv_req;
  logic        inv_busy;
  logic [31:0] mem_req_addr;
  logic        mem_req_valid;
  logic [31:0] mem_req_data;
  logic        mem_req_ready;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int tests = 0;
  int fails = 0;
  logic [31:0] req_addr;
  logic [31:0] beat_log[$];

  icache_sa #(
    .ADDR_W(32),
    .DATA_W(32),
    .SETS(16),
    .WORDS(4),
    .WAYS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_req_addr(cpu_req_addr),
    .cpu_req_valid(cpu_req_valid),
    .cpu_req_data(cpu_req_data),
    .cpu_req_ready(cpu_req_ready),
    .inv_req(inv_req),
    .inv_busy(inv_busy),
    .mem_req_addr(mem_req_addr),
    .mem_req_valid(mem_req_valid),
    .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line 0x1000 holds 0xA0..0xA3; other lines carry a tag-derived upper half.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:8] - 24'h10, 8'hA0 | {6'b0, a[3:2]}};
  endfunction

  assign mem_req_data = mem_word(mem_req_addr);

  always @(posedge clk) begin
    if (rst && mem_req_valid && mem_req_ready) beat_log.push_back(mem_req_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [31:0] a);
    beat_log.delete();
    req_addr      = a;
    cpu_req_addr  = a;
    cpu_req_valid = 1'b1;
  endtask

  task automatic wait_resp(input string tag, input logic [31:0] exp_d, input int exp_lat,
                           input int exp_beats, input int stall_beat, input int stall_n);
    int lat;
    int stalls;
    bit got;
    logic [31:0] base;
    lat    = 0;
    stalls = 0;
    got    = 1'b0;
    base   = {req_addr[31:4], 4'h0};
    mem_req_ready = 1'b1;
    while (!got && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (cpu_req_ready) begin
        got = 1'b1;
      end else if (mem_req_valid && stalls < stall_n && beat_log.size() == stall_beat) begin
        check({tag, "_stall_addr"}, mem_req_addr, base + 32'(4 * stall_beat));
        mem_req_ready = 1'b0;
        stalls++;
      end else begin
        mem_req_ready = 1'b1;
      end
    end
    mem_req_ready = 1'b1;
    check({tag, "_ready"}, {31'b0, got}, 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, cpu_req_data, exp_d);
    check({tag, "_beats"}, 32'(beat_log.size()), 32'(exp_beats));
    for (int i = 0; i < beat_log.size(); i++) begin
      check({tag, "_beat_addr"}, beat_log[i], base + 32'(4 * i));
    end
    cpu_req_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_single_pulse"}, {31'b0, cpu_req_ready}, 32'd0);
  endtask

  task automatic do_inv(input bit with_req, input logic [31:0] a);
    int n;
    bit early;
    inv_req = 1'b1;
    @(posedge clk);
    #1;
    inv_req = 1'b0;
    if (with_req) start_req(a);
    n     = 0;
    early = 1'b0;
    while (inv_busy && n < 100) begin
      n++;
      if (cpu_req_ready || mem_req_valid) early = 1'b1;
      @(posedge clk);
      #1;
    end
    check("inv_busy_cycles", 32'(n), 32'd16);
    check("inv_blocks_req", {31'b0, early}, 32'd0);
  endtask

  initial begin
    int guard;
    rst           = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_valid = 1'b0;
    inv_req       = 1'b0;
    mem_req_ready = 1'b1;
    req_addr      = '0;
    repeat (3) @(negedge clk);

    check("rst_ready", {31'b0, cpu_req_ready}, 32'd0);
    check("rst_data", cpu_req_data, 32'd0);
    check("rst_mem_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_mem_addr", mem_req_addr, 32'd0);
    check("rst_inv_busy", {31'b0, inv_busy}, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss, then a hit in the same line
    start_req(32'h0000_1004);
    wait_resp("cold_miss", 32'h0000_00A1, 6, 4, 0, 0);
    check("cold_miss_cnt", miss_cnt, 32'd1);
    check("cold_hit_cnt", hit_cnt, 32'd0);
    start_req(32'h0000_1008);
    wait_resp("hit_1008", 32'h0000_00A2, 2, 0, 0, 0);
    check("hit1_hit_cnt", hit_cnt, 32'd1);
    check("hit1_miss_cnt", miss_cnt, 32'd1);

    // LRU replacement within set 0
    start_req(32'h0000_1000);
    wait_resp("hit_1000_a", 32'h0000_00A0, 2, 0, 0, 0);
    start_req(32'h0000_2000);
    wait_resp("fill_2000", 32'h0000_10A0, 6, 4, 0, 0);
    start_req(32'h0000_1000);
    wait_resp("hit_1000_b", 32'h0000_00A0, 2, 0, 0, 0);
    start_req(32'h0000_3000);
    wait_resp("fill_3000", 32'h0000_20A0, 6, 4, 0, 0);
    start_req(32'h0000_1000);
    wait_resp("hit_1000_c", 32'h0000_00A0, 2, 0, 0, 0);
    start_req(32'h0000_2000);
    wait_resp("remiss_2000", 32'h0000_10A0, 6, 4, 0, 0);
    check("lru_hit_cnt", hit_cnt, 32'd4);
    check("lru_miss_cnt", miss_cnt, 32'd4);

    // Invalidate in IDLE with a fetch raised during the flush
    do_inv(1'b1, 32'h0000_1000);
    wait_resp("inv_miss_1000", 32'h0000_00A0, 6, 4, 0, 0);
    check("inv_miss_cnt", miss_cnt, 32'd5);
    check("inv_hit_cnt", hit_cnt, 32'd4);

    // Refill stalled three cycles at beat 2
    do_inv(1'b0, 32'h0);
    start_req(32'h0000_1004);
    wait_resp("stall", 32'h0000_00A1, 9, 4, 2, 3);
    check("stall_miss_cnt", miss_cnt, 32'd6);

    // Reset during beat 1 of a refill
    start_req(32'h0000_2004);
    mem_req_ready = 1'b1;
    guard = 0;
    while (!(mem_req_valid && mem_req_addr == 32'h0000_2004) && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("rst_beat1_reached", {31'b0, mem_req_valid}, 32'd1);
    rst = 1'b0;
    cpu_req_valid = 1'b0;
    #1;
    check("abort_mem_valid", {31'b0, mem_req_valid}, 32'd0);
    check("abort_mem_addr", mem_req_addr, 32'd0);
    check("abort_ready", {31'b0, cpu_req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    check("abort_hit_cnt", hit_cnt, 32'd0);
    check("abort_miss_cnt", miss_cnt, 32'd0);
    start_req(32'h0000_1000);
    wait_resp("post_rst_1000", 32'h0000_00A0, 6, 4, 0, 0);
    start_req(32'h0000_2000);
    wait_resp("post_rst_2000", 32'h0000_10A0, 6, 4, 0, 0);
    check("post_rst_miss_cnt", miss_cnt, 32'd2);
    check("post_rst_hit_cnt", hit_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised, set-associative, read-only instruction cache with multi-word lines; successor to the single-word direct-mapped I-cache.
- Sits between the IF stage (cpu_req_* side) and instruction memory (mem_req_* side).
- Adds burst line refill with per-beat handshake, LRU replacement, whole-cache invalidate (fence.i) and hit/miss counters.
- Read-only: no dirty bits, no write-back path.

Parameters:
- ADDR_W, 32, address and counter width.
- DATA_W, 32, instruction word width.
- SETS, 16, number of sets; power of 2, ≥2.
- WORDS, 4, words per line; power of 2, ≥2.
- WAYS, 2, associativity; 1 or 2 supported.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous reset, active-low.
- cpu_req_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- cpu_req_valid  in  1  fetch request; held with a stable address up to and including the cpu_req_ready cycle.
- cpu_req_data  out  DATA_W  fetched word; valid only while cpu_req_ready=1.
- cpu_req_ready  out  1  one-cycle response pulse.
- inv_req  in  1  invalidate-all request pulse.
- inv_busy  out  1  high while a pending or in-progress invalidate exists.
- mem_req_addr  out  ADDR_W  refill beat address.
- mem_req_valid  out  1  refill beat request.
- mem_req_data  in  DATA_W  refill beat data.
- mem_req_ready  in  1  beat accepted; mem_req_data valid in the same cycle.
- hit_cnt  out  ADDR_W  count of hits; wraps.
- miss_cnt  out  ADDR_W  count of misses; wraps.

Behaviour:

Address split:
- Word offset = [2+log2(WORDS)-1:2].
- Index = next log2(SETS) bits.
- Tag = remaining upper bits.

Storage:
- Per way: valid bit and tag per set; data array of SETS×WORDS words.
- Per set: one LRU bit when WAYS=2.

Reset (rst=0, asynchronous):
- State goes to IDLE.
- All valid bits, LRU bits, beat counter, pending-invalidate flag, hit_cnt and miss_cnt are cleared.
- All outputs are 0.
- Data arrays are not reset.
- Reset during REFILL or FLUSH aborts it immediately; the partially filled line stays invalid.

FSM:
- IDLE:
  - If inv pending (or inv_req=1) → FLUSH.
  - Else if cpu_req_valid=1 → latch address, go to COMPARE.
- COMPARE: a way hits when valid and tag match.
  - Hit: register the word and go to RESPOND; hit_cnt+1; LRU[set] points to the other way.
  - Miss: choose victim (lowest-numbered invalid way, else the LRU way); miss_cnt+1; → REFILL with beat=0.
- REFILL:
  - mem_req_valid=1 and mem_req_addr={tag,index,beat,2'b00}; beats are ascending from the line base.
  - On mem_req_ready=1: write the beat into the victim way, capture it if beat equals the requested word, beat+1.
  - On mem_req_ready=0: address and beat are held.
  - After the last beat is accepted: mem_req_valid drops on the next edge; set valid and tag; LRU points to the other way; → RESPOND.
- RESPOND: cpu_req_ready=1 with cpu_req_data for exactly one cycle, then → IDLE.
- FLUSH: clear the valid bits of one set per cycle (index 0..SETS-1) across all ways, clear LRU, then → IDLE. inv_busy clears at the same time.

Latency:
- Hit: valid sampled at cycle 0 → ready at cycle 2.
- Miss: 2 + WORDS + stall cycles.
- The cycle after a ready pulse may carry a new request.

Invalidate rules:
- inv_req asserted in any state other than IDLE sets the pending flag; inv_busy rises on the next edge.
- The flush starts at the next IDLE and takes priority over cpu_req_valid.
- inv_req during FLUSH is absorbed.

WAYS=1:
- Victim is always way 0; LRU logic is removed.

Counters:
- Wrap modulo 2^ADDR_W with no saturation.

Test Plan:
Test configuration: SETS=16, WORDS=4, WAYS=2, so index=[7:4] and tag=[31:8].
1. Cold miss at 0x0000_1004; memory returns 0xA0..0xA3 for 0x1000..0x100C with ready always high → exactly 4 beats at 0x1000, 0x1004, 0x1008, 0x100C; cpu_req_data=0xA1 with a single ready pulse; miss_cnt=1.
2. Then fetch 0x0000_1008 → ready 2 cycles after valid, data=0xA2, mem_req_valid stays 0, hit_cnt=1.
3. Fill 0x1000 then 0x2000 (both index 0); hit 0x1000; miss 0x3000 → 0x3000 evicts 0x2000; 0x1000 still hits; 0x2000 misses again.
4. Pulse inv_req in IDLE after lines are resident → inv_busy high for 16 cycles; a cpu_req_valid asserted meanwhile is delayed; 0x1000 then misses.
5. Hold mem_req_ready=0 for 3 cycles at beat 2 → mem_req_addr held at 0x1008 and beat count unchanged; completion is 3 cycles later.
6. Drive rst=0 during beat 1 → mem_req_valid=0 immediately; after release, 0x1000 misses and hit_cnt=miss_cnt=0 before the access.
